// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Runs a req/ack fetch handshake with a variable-latency imem. A skid buffer
// parks a word that arrives while D is stalled. Memory wait states reach decode
// as bubbles, so this stage never stalls the rest of the pipeline.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [5:0]  opD,
  output logic [5:0]  functD
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_n;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_skid;
  logic [31:0] r_redir;

  logic [31:0] w_pc_n;
  logic [31:0] w_instr_n;
  logic [31:0] w_pc4_n;
  logic        w_valid_n;
  logic [31:0] w_skid_n;
  logic [31:0] w_redir_n;

  logic        w_advance;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_advance  = !stallD;
  assign w_redirect = w_advance & r_valid & (jumpD | pcsrcD);
  assign w_target   = jumpD ? {r_pc4[31:28], r_instr[25:0], 2'b00} : pcbranchD;
  assign w_pc_plus4 = r_pc + 32'd4;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_state_n;
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          if (!w_advance) w_state_n = S_HOLD;
        end else if (w_redirect) begin
          w_state_n = S_DROP;
        end
      end
      S_DROP:  if (imem_ack)  w_state_n = S_FETCH;
      S_HOLD:  if (w_advance) w_state_n = S_FETCH;
      default: w_state_n = S_FETCH;
    endcase
  end

  // FSM outputs: request stays up while a response is owed to us
  always_comb begin
    imem_req = 1'b0;
    if ((r_state == S_FETCH) || (r_state == S_DROP)) imem_req = 1'b1;
  end

  // Datapath next values: PC, IF/ID register, skid buffer, pending redirect
  always_comb begin
    w_pc_n    = r_pc;
    w_instr_n = r_instr;
    w_pc4_n   = r_pc4;
    w_valid_n = r_valid;
    w_skid_n  = r_skid;
    w_redir_n = r_redir;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          if (w_advance) begin
            if (w_redirect) begin
              w_instr_n = 32'h0;
              w_valid_n = 1'b0;
              w_pc_n    = w_target;
            end else if (flushD) begin
              w_instr_n = 32'h0;
              w_valid_n = 1'b0;
              w_pc_n    = w_pc_plus4;
            end else begin
              w_instr_n = imem_rdata;
              w_pc4_n   = w_pc_plus4;
              w_valid_n = 1'b1;
              w_pc_n    = w_pc_plus4;
            end
          end else begin
            w_skid_n = imem_rdata;
          end
        end else begin
          if (w_advance) begin
            w_instr_n = 32'h0;
            w_valid_n = 1'b0;
          end
          // Address must stay stable until the ack, so park the target
          if (w_redirect) w_redir_n = w_target;
        end
      end
      S_DROP: begin
        if (w_advance) begin
          w_instr_n = 32'h0;
          w_valid_n = 1'b0;
        end
        if (imem_ack) w_pc_n = r_redir;
      end
      S_HOLD: begin
        if (w_advance) begin
          if (w_redirect) begin
            w_instr_n = 32'h0;
            w_valid_n = 1'b0;
            w_pc_n    = w_target;
          end else if (flushD) begin
            w_instr_n = 32'h0;
            w_valid_n = 1'b0;
            w_pc_n    = w_pc_plus4;
          end else begin
            w_instr_n = r_skid;
            w_pc4_n   = w_pc_plus4;
            w_valid_n = 1'b1;
            w_pc_n    = w_pc_plus4;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
      r_skid  <= 32'h0;
      r_redir <= 32'h0;
    end else begin
      r_pc    <= w_pc_n;
      r_instr <= w_instr_n;
      r_pc4   <= w_pc4_n;
      r_valid <= w_valid_n;
      r_skid  <= w_skid_n;
      r_redir <= w_redir_n;
    end
  end

  assign imem_addr = r_pc;
  assign instrD    = r_instr;
  assign pcplus4D  = r_pc4;
  assign validD    = r_valid;
  assign opD       = r_instr[31:26];
  assign functD    = r_instr[5:0];

endmodule
